// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Y86 5-stage stall/bubble control, halt/single-step sequencer
//            and saturating performance counters.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int         CNT_W  = 32,
  parameter logic [3:0] RSP_ID = 4'd5,
  parameter logic [3:0] RNONE  = 4'd15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic [3:0]       W_icode,
  input  logic             step_mode,
  input  logic             step_req,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] misp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STEP_WAIT = 2'd1,
    ST_STEP_GO   = 2'd2,
    ST_HALTED    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  logic load_use;
  logic ret_fl;
  logic misp;
  logic exc_m;
  logic exc_w;
  logic advancing;
  logic ret_retire;

  // %rsp hazards exactly like any other register, so it needs no special case.
  logic unused_params;
  assign unused_params = ^RSP_ID;

  always_comb begin
    load_use   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                 (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_fl     = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    misp       = (E_icode == I_JXX) && !e_cnd;
    exc_m      = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
    exc_w      = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);
    ret_retire = (W_icode == I_RET) && (W_stat == S_AOK);
    advancing  = (state_q == ST_RUN) || (state_q == ST_STEP_GO);
  end

  // Frozen states hold F/D/W and inject nothing.
  always_comb begin
    F_stall  = 1'b1;
    D_stall  = 1'b1;
    W_stall  = 1'b1;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    if (advancing) begin
      F_stall  = load_use || ret_fl;
      D_stall  = load_use;
      D_bubble = misp || (ret_fl && !load_use);
      E_bubble = misp || load_use;
      M_bubble = exc_m || exc_w;
      W_stall  = exc_w;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_STEP_GO: begin
        if (exc_w)          state_d = ST_HALTED;
        else if (step_mode) state_d = ST_STEP_WAIT;
        else                state_d = ST_RUN;
      end
      ST_STEP_WAIT: begin
        if (!step_mode)     state_d = ST_RUN;
        else if (step_req)  state_d = ST_STEP_GO;
        else                state_d = ST_STEP_WAIT;
      end
      ST_HALTED:            state_d = ST_HALTED;
      default:              state_d = ST_RUN;
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != {CNT_W{1'b1}})) ? (v + CNT_ONE) : v;
  endfunction

  always_comb begin
    cyc_cnt_d   = sat_inc(cyc_cnt_q,   advancing);
    stall_cnt_d = sat_inc(stall_cnt_q, advancing && F_stall);
    misp_cnt_d  = sat_inc(misp_cnt_q,  advancing && misp);
    ret_cnt_d   = sat_inc(ret_cnt_q,   advancing && ret_retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      halted_q    <= 1'b0;
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      misp_cnt_q  <= '0;
      ret_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      cyc_cnt_q   <= cyc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      misp_cnt_q  <= misp_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  assign halted    = halted_q;
  assign cyc_cnt   = cyc_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign misp_cnt  = misp_cnt_q;
  assign ret_cnt   = ret_cnt_q;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline control unit for the 5-stage Y86 core. Each cycle it raises stall/bubble requests for the F, D, E, M and W pipeline registers. Triggers: load-use hazards the decode forwarding network cannot cover, ret-in-flight, mispredicted jXX, and exception status. It also provides a halt/single-step sequencer and saturating performance counters for the testbench and debug.

Parameters:
CNT_W, 32, width of each performance counter
RSP_ID, 5, register ID of %rsp as used by decode
RNONE, 15, register ID meaning "no register"

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
D_icode  in  4  icode in D register
d_srcA  in  4  decode source A ID (RNONE if unused)
d_srcB  in  4  decode source B ID (RNONE if unused)
E_icode  in  4  icode in E register
E_dstM  in  4  memory destination in E register
e_cnd  in  1  condition result of execute stage
M_icode  in  4  icode in M register
m_stat  in  3  memory-stage status (AOK=1, HLT=2, ADR=3, INS=4)
W_stat  in  3  writeback-stage status
W_icode  in  4  icode in W register
step_mode  in  1  1 = single-step debug mode
step_req  in  1  one-cycle pulse: advance one cycle in step mode
F_stall, D_stall, W_stall  out  1 each  hold pipeline register
D_bubble, E_bubble, M_bubble  out  1 each  load nop bubble
halted  out  1  core stopped on exception/halt
cyc_cnt, stall_cnt, misp_cnt, ret_cnt  out  CNT_W each  performance counters

Behaviour:
- Stall/bubble outputs are combinational from inputs and registered state. The counters, state and halted are registered.
- Icodes: HALT 0, NOP 1, JXX 7, RET 9, MRMOVQ 5, POPQ B.
- load_use = (E_icode is MRMOVQ or POPQ) and E_dstM != RNONE and (E_dstM == d_srcA or E_dstM == d_srcB).
- ret_fl = RET present in D_icode, E_icode or M_icode.
- misp = (E_icode == JXX) and e_cnd == 0.
- exc_m = m_stat in {HLT, ADR, INS}. exc_w = W_stat in {HLT, ADR, INS}.
- Normal control (state RUN or STEP_GO):
  - F_stall = load_use or ret_fl
  - D_stall = load_use
  - D_bubble = misp or (ret_fl and not load_use)
  - E_bubble = misp or load_use
  - M_bubble = exc_m or exc_w
  - W_stall = exc_w
- Frozen control (state STEP_WAIT or HALTED): F_stall = D_stall = W_stall = 1; all bubbles = 0.
- State machine, reset state RUN:
  - RUN -> HALTED if exc_w; else -> STEP_WAIT if step_mode; else stay.
  - STEP_WAIT -> RUN if step_mode == 0; else -> STEP_GO if step_req; else stay.
  - STEP_GO lasts exactly one cycle. -> HALTED if exc_w; else -> STEP_WAIT if step_mode; else -> RUN.
  - HALTED is sticky; only rst_n exits it.
  - exc_w takes priority over step_mode.
- halted = 1 exactly in HALTED.
- Counters update only in advancing cycles, i.e. state RUN or STEP_GO:
  - cyc_cnt += 1
  - stall_cnt += 1 if F_stall
  - misp_cnt += 1 if misp
  - ret_cnt += 1 when W_icode == RET and W_stat == AOK
  - Every counter saturates at all-ones and never wraps.
- step_req is ignored outside STEP_WAIT. A step_req held high gives one STEP_GO per two cycles (GO, WAIT, GO, ...).
- Reset (asserted at any time, including mid-step or while HALTED): state = RUN, halted = 0, all counters = 0, immediately and without a clock edge. Outputs then follow normal control from the current inputs.
- Load-use and misp in the same cycle: E_bubble = 1, D_stall = 1, D_bubble = 1 (the pipeline register applies stall over bubble). This is legal and requires no special handling.

Test Plan:
- Load-use: E_icode = 5, E_dstM = 3, d_srcA = 3, all stats AOK -> F_stall = 1, D_stall = 1, E_bubble = 1, D_bubble = 0; stall_cnt 0 -> 1 after one edge.
- ret: D_icode = 9, no load-use -> F_stall = 1, D_bubble = 1. Then W_icode = 9 with W_stat = 1 for one cycle -> ret_cnt = 1.
- Mispredict: E_icode = 7, e_cnd = 0 -> D_bubble = 1, E_bubble = 1, F_stall = 0; misp_cnt increments by 1.
- Exception: m_stat = 3 -> M_bubble = 1. Next cycle W_stat = 3 -> W_stall = 1, state HALTED, halted = 1 on the following edge, all stalls = 1, cyc_cnt frozen. rst_n low -> halted = 0 asynchronously, counters = 0.
- Single-step: step_mode = 1 for 10 cycles with step_req pulsed 3 times -> cyc_cnt advances by exactly 3, and frozen outputs are held between pulses.
- Saturation: force 2^CNT_W - 1 advancing cycles (CNT_W = 4 build) -> cyc_cnt stays at 15.
